// File: rtl/common_pkg.sv
// Shared decode definitions for the ID stage.
//   - RV32I major opcode constants
//   - alu_op_e: ALU operation selector carried in the control bundle
//   - imm_fmt_e: immediate encoding formats
//   - control_type: packed control bundle handed to execute
//   - alu_from_funct: funct3/funct7 -> ALU operation helper
package common;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALU_ADD is zero so an all-zero bundle is a harmless bubble.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;     // 1: operand B is the immediate
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    is_branch;
    logic    is_jump;
  } control_type;

  // alt is instr[30]; it selects SUB only for register-register ops,
  // since OP-IMM has no SUBI and bit 30 is immediate data there.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3,
                                             input logic       alt,
                                             input logic       is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// register_file: 32x32 integer register file, 2 combinational read ports,
// 1 synchronous write port. x0 is hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write is forwarded onto a
// read port whose index matches; otherwise reads see the pre-write value.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset (clears all)
//   rs1_addr/rs1_data       read port 1
//   rs2_addr/rs2_data       read port 2
//   write_en/id/data        writeback port (writes to x0 discarded)
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        write_en,
  input  logic [4:0]  write_id,
  input  logic [31:0] write_data
);

  logic [31:0] regs [32];
  logic        wr_ok;
  logic        hit1, hit2;

  assign wr_ok = write_en && (write_id != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[write_id] <= write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = wr_ok && (write_id == rs1_addr);
  assign hit2 = wr_ok && (write_id == rs2_addr);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // wr_ok already excludes x0, so a hit never overrides the zero read.
  assign rs1_data = hit1 ? write_data : ((rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr]);
  assign rs2_data = hit2 ? write_data : ((rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr]);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode plus the ID/EX pipeline register.
// Reads operands from register_file, builds the immediate and control
// bundle, and registers everything with 1-cycle latency.
// Optional macro REGFILE_BYPASS_EN (handled inside register_file).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   instruction_in, program_counter_in, compflg_in   from fetch
//   stall_in                         hold ID/EX contents
//   flush_in                         load a bubble (wins over stall_in)
//   write_en, write_id, write_data   writeback port
//   data1, data2, immediate_data, control_out, compflg_out,
//   program_counter_out, illegal_instr                ID/EX outputs
module decode_stage
  import common::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_in,
  input  logic [31:0] program_counter_in,
  input  logic        compflg_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        write_en,
  input  logic [4:0]  write_id,
  input  logic [31:0] write_data,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] immediate_data,
  output control_type control_out,
  output logic        compflg_out,
  output logic [31:0] program_counter_out,
  output logic        illegal_instr
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] rs1_val, rs2_val, imm;
  control_type ctrl;
  imm_fmt_e    fmt;
  logic        illegal;

  assign instr  = instruction_in;
  assign opcode = instr[6:0];

  // Writes during reset are suppressed inside register_file by its reset
  // branch, so an in-flight writeback is dropped on a reset edge.
  register_file u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr   (instr[19:15]),
    .rs2_addr   (instr[24:20]),
    .rs1_data   (rs1_val),
    .rs2_data   (rs2_val),
    .write_en   (write_en),
    .write_id   (write_id),
    .write_data (write_data)
  );

  always_comb begin
    ctrl    = '0;
    fmt     = IMM_R;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_op    = alu_from_funct(instr[14:12], instr[30], 1'b1);
        ctrl.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt            = IMM_I;
        ctrl.alu_op    = alu_from_funct(instr[14:12], instr[30], 1'b0);
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        fmt             = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        fmt            = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        fmt            = IMM_B;
        ctrl.alu_op    = ALU_SUB;  // compare rs1 against rs2
        ctrl.is_branch = 1'b1;
      end
      OPC_JAL: begin
        fmt            = IMM_J;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_jump   = 1'b1;
      end
      OPC_JALR: begin
        fmt            = IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_jump   = 1'b1;
      end
      OPC_LUI: begin
        fmt            = IMM_U;
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        fmt            = IMM_U;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // ID/EX register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_in) begin
      data1               <= '0;
      data2               <= '0;
      immediate_data      <= '0;
      control_out         <= '0;
      compflg_out         <= 1'b0;
      program_counter_out <= '0;
      illegal_instr       <= 1'b0;
    end else if (!stall_in) begin
      data1               <= rs1_val;
      data2               <= rs2_val;
      immediate_data      <= imm;
      control_out         <= ctrl;
      compflg_out         <= compflg_in;
      program_counter_out <= program_counter_in;
      illegal_instr       <= illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, compared each cycle against an opcode-table
// reference model with its own register array.
module tb_decode_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_in, program_counter_in;
  logic        compflg_in, stall_in, flush_in, write_en;
  logic [4:0]  write_id;
  logic [31:0] write_data;
  logic [31:0] data1, data2, immediate_data, program_counter_out;
  control_type control_out;
  logic        compflg_out, illegal_instr;

  int n_checks = 0;
  int n_err    = 0;

  // reference state
  logic [31:0] ref_rf [32];
  logic [31:0] e_d1, e_d2, e_imm, e_pc;
  control_type e_ctrl;
  logic        e_cf, e_ill;

  decode_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_in      (instruction_in),
    .program_counter_in  (program_counter_in),
    .compflg_in          (compflg_in),
    .stall_in            (stall_in),
    .flush_in            (flush_in),
    .write_en            (write_en),
    .write_id            (write_id),
    .write_data          (write_data),
    .data1               (data1),
    .data2               (data2),
    .immediate_data      (immediate_data),
    .control_out         (control_out),
    .compflg_out         (compflg_out),
    .program_counter_out (program_counter_out),
    .illegal_instr       (illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference decode written from the ISA opcode table.
  function automatic void ref_decode(input logic [31:0] i, output control_type c,
                                     output logic [31:0] imm, output logic ill);
    alu_op_e     f3map [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                               ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [31:0] iimm = 32'($signed(i) >>> 20);
    logic [2:0]  f3   = i[14:12];
    c = '0; imm = 32'd0; ill = 1'b0;
    case (i[6:0])
      7'h33: begin
        c.alu_op = f3map[f3];
        if (i[30] && f3 == 3'd0) c.alu_op = ALU_SUB;
        if (i[30] && f3 == 3'd5) c.alu_op = ALU_SRA;
        c.reg_write = 1'b1;
      end
      7'h13: begin
        c.alu_op = f3map[f3];
        if (i[30] && f3 == 3'd5) c.alu_op = ALU_SRA;
        c.alu_src = 1'b1; c.reg_write = 1'b1; imm = iimm;
      end
      7'h03: begin
        c.alu_src = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
        imm = iimm;
      end
      7'h23: begin
        c.alu_src = 1'b1; c.mem_write = 1'b1;
        imm = {iimm[31:5], i[11:7]};
      end
      7'h63: begin
        c.alu_op = ALU_SUB; c.is_branch = 1'b1;
        imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h6F: begin
        c.alu_src = 1'b1; c.reg_write = 1'b1; c.is_jump = 1'b1;
        imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin
        c.alu_src = 1'b1; c.reg_write = 1'b1; c.is_jump = 1'b1; imm = iimm;
      end
      7'h37: begin
        c.alu_op = ALU_PASS_B; c.alu_src = 1'b1; c.reg_write = 1'b1;
        imm = i & 32'hFFFFF000;
      end
      7'h17: begin
        c.alu_src = 1'b1; c.reg_write = 1'b1; imm = i & 32'hFFFFF000;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    logic [31:0] v = (a == 5'd0) ? 32'd0 : ref_rf[a];
`ifdef REGFILE_BYPASS_EN
    if (write_en && write_id != 5'd0 && write_id == a) v = write_data;
`endif
    return v;
  endfunction

  // Update the model for the coming edge, advance one clock, compare all outputs.
  task automatic cycle();
    control_type c;
    logic [31:0] imm;
    logic        ill;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) ref_rf[r] = 32'd0;
      e_d1 = 0; e_d2 = 0; e_imm = 0; e_ctrl = '0; e_cf = 0; e_pc = 0; e_ill = 0;
    end else begin
      ref_decode(instruction_in, c, imm, ill);
      if (flush_in) begin
        e_d1 = 0; e_d2 = 0; e_imm = 0; e_ctrl = '0; e_cf = 0; e_pc = 0; e_ill = 0;
      end else if (!stall_in) begin
        e_d1 = ref_read(instruction_in[19:15]);
        e_d2 = ref_read(instruction_in[24:20]);
        e_imm = imm; e_ctrl = c; e_cf = compflg_in; e_pc = program_counter_in; e_ill = ill;
      end
      if (write_en && write_id != 5'd0) ref_rf[write_id] = write_data;
    end
    @(posedge clk);
    #1;
    chk("data1", data1, e_d1);
    chk("data2", data2, e_d2);
    chk("imm", immediate_data, e_imm);
    chk("ctrl", 32'(control_out), 32'(e_ctrl));
    chk("compflg", 32'(compflg_out), 32'(e_cf));
    chk("pc", program_counter_out, e_pc);
    chk("illegal", 32'(illegal_instr), 32'(e_ill));
  endtask

  task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] wid,
                       input logic [31:0] wd);
    instruction_in = ins; write_en = we; write_id = wid; write_data = wd;
    program_counter_in = program_counter_in + 32'd4;
    compflg_in = ~compflg_in;
  endtask

  logic [6:0] legal_opc [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  initial begin
    rst_n = 1'b0; stall_in = 0; flush_in = 0;
    instruction_in = 32'h00000013; program_counter_in = 32'h1000; compflg_in = 0;
    write_en = 1; write_id = 5'd5; write_data = 32'h12345678;
    for (int r = 0; r < 32; r++) ref_rf[r] = 32'hX;

    // reset state (write during reset must be dropped)
    cycle();
    chk("rst_data1", data1, 32'd0);
    rst_n = 1'b1;

    // write x5, then addi x6,x5,1
    drive(32'h00000013, 1, 5'd5, 32'hDEADBEEF); cycle();
    drive(32'h00128313, 0, 5'd0, 32'd0);        cycle();
    chk("addi_data1", data1, 32'hDEADBEEF);
    chk("addi_imm", immediate_data, 32'h1);
    chk("addi_reg_write", 32'(control_out.reg_write), 32'd1);
    chk("addi_alu_src", 32'(control_out.alu_src), 32'd1);

    // x0 write discarded; negative I immediate
    drive(32'h00000013, 1, 5'd0, 32'h00001234); cycle();
    drive(32'h00000013, 0, 5'd0, 32'd0);        cycle();
    chk("x0_read", data1, 32'd0);
    drive(32'hFFF00093, 0, 5'd0, 32'd0);        cycle();
    chk("neg_imm", immediate_data, 32'hFFFFFFFF);

    // same-cycle write and read of x5
    drive(32'h00128313, 1, 5'd5, 32'hA5A5A5A5); cycle();
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data1", data1, 32'hA5A5A5A5);
`else
    chk("nobypass_data1", data1, 32'hDEADBEEF);
`endif
    drive(32'h00128313, 0, 5'd0, 32'd0); cycle();
    chk("after_write_data1", data1, 32'hA5A5A5A5);

    // stall 3 cycles with changing instruction; write still lands
    stall_in = 1;
    drive(32'h00500113, 1, 5'd7, 32'h77);     cycle();
    drive(32'hFE20AE23, 0, 5'd0, 32'd0);      cycle();
    drive(32'h000380B7, 0, 5'd0, 32'd0);      cycle();
    chk("stall_hold_imm", immediate_data, 32'h1);
    chk("stall_hold_pc", program_counter_out, e_pc);
    flush_in = 1; cycle();
    chk("flush_stall_ctrl", 32'(control_out), 32'd0);
    chk("flush_stall_d1", data1, 32'd0);
    stall_in = 0; flush_in = 0;
    drive(32'h00038013, 0, 5'd0, 32'd0); cycle();
    chk("stalled_write_x7", data1, 32'h77);

    // illegal opcode
    drive(32'h0000007F, 0, 5'd0, 32'd0); cycle();
    chk("illegal_flag", 32'(illegal_instr), 32'd1);
    chk("illegal_ctrl", 32'(control_out), 32'd0);

    // reset mid-stream, then read x5
    rst_n = 0; drive(32'h00128313, 1, 5'd9, 32'h99); cycle();
    chk("midrst_d1", data1, 32'd0);
    chk("midrst_pc", program_counter_out, 32'd0);
    rst_n = 1; drive(32'h00028013, 0, 5'd0, 32'd0); cycle();
    chk("x5_after_rst", data1, 32'd0);
    drive(32'h00048013, 0, 5'd0, 32'd0); cycle();
    chk("x9_dropped", data1, 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      int sel;
      ins = $urandom();
      sel = $urandom_range(0, 10);
      if (sel < 9)       ins[6:0] = legal_opc[sel];
      else if (sel == 9) ins[6:0] = 7'h7F;
      drive(ins, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom());
      stall_in = ($urandom_range(0, 3) == 0);
      flush_in = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
